toggle_activity_monitor: RTL
============================

# toggle_activity_monitor

Per-channel switching-activity counter that sits directly downstream of the standard-cell test structures (combinational and sequential UDP cells, flop variants) in the power-analysis benches. It samples NCH probed cell outputs, counts rising and falling transitions over a fixed capture window, and streams the per-channel totals out over a valid/ready handshake. Results feed the toggle-count logging that is compared against the gate-level power flow.

## Interface
- NCH, 4, number of probed channels (≥1)
- CW, 16, counter width per edge type (≥2)
- WINDOW, 64, capture length in CLK cycles (≥1, ≤ 2^16)
- CLK  input  1  sole clock, all state updates on posedge
- RN  input  1  reset, asynchronous, active-low
- PROBE  input  NCH  monitored cell outputs
- START  input  1  begin capture; sampled only in IDLE
- BUSY  output  1  high in CAPTURE and DRAIN
- OUT_VALID  output  1  result beat valid
- OUT_READY  input  1  consumer accepts beat
- OUT_CH  output  max(1,$clog2(NCH))  channel index of current beat
- OUT_RISE  output  CW  rising-edge count of OUT_CH
- OUT_FALL  output  CW  falling-edge count of OUT_CH
- OUT_OVF  output  1  either counter of OUT_CH saturated

## Operation
- States: IDLE, CAPTURE, DRAIN.
- IDLE: START=1 → CAPTURE; same edge: all counters and OVF cleared, prev ← sampled probe, window counter ← 0.
- CAPTURE: each cycle, per channel: rise = ~prev & p, fall = prev & ~p; counters increment on rise/fall; prev ← p; window counter increments.
- Counters saturate at 2^CW−1; a saturating increment attempt sets the sticky per-channel OVF.
- Window counter == WINDOW−1 → that cycle's edges counted, then → DRAIN with channel index 0.
- DRAIN: OUT_VALID=1; OUT_CH/OUT_RISE/OUT_FALL/OUT_OVF reflect current index; held stable while OUT_READY=0. OUT_VALID & OUT_READY → index+1; acceptance at index NCH−1 → IDLE.
- START outside IDLE is ignored (no restart, no error).
- Edges at the START cycle itself are not counted (prev loaded, not compared).

## Timing
- Reset (RN low, any state, including mid-capture/drain): state IDLE, BUSY=0, OUT_VALID=0, OUT_CH=0, OUT_RISE=0, OUT_FALL=0, OUT_OVF=0, counters/OVF/prev/window/index cleared. Release takes effect on first posedge with RN high.
- START high at edge k → BUSY=1 from k+1; sampled edges at k+1 … k+WINDOW counted.
- OUT_VALID rises at edge k+WINDOW+1; minimum drain NCH cycles with OUT_READY held high.
- Final acceptance at edge m → BUSY=0, OUT_VALID=0 from m+1; START at m+1 accepted.
- All outputs registered; no combinational path OUT_READY → OUT_VALID.

## Configuration
- TOGGLE_MON_SYNC_EN defined: PROBE passes through a 2-flop synchronizer per channel (reset 0) before edge detection; counted window shifts 2 cycles later relative to PROBE, counts otherwise identical.
- Undefined: PROBE sampled directly (probes assumed CLK-synchronous); zero added latency.

## Structure
- Package toggle_mon_pkg: state enum (IDLE, CAPTURE, DRAIN), result struct {ch, rise, fall, ovf}, saturating-increment function.
- Sub-module toggle_mon_chan: one channel's prev flop, edge detect, two saturating counters, sticky OVF; clear and enable inputs from the top-level FSM; instantiated NCH times via generate.

## Test plan
- NCH=4, WINDOW=64, PROBE[0] toggling every cycle, PROBE[1] constant 1, others 0 → beats ch0 rise=32 fall=32, ch1..3 rise=0 fall=0, OVF=0.
- CW=4, PROBE[0] toggling every cycle → ch0 rise=15 fall=15 OVF=1; other channels OVF=0.
- OUT_READY low for 10 cycles at ch0 → OUT_VALID stays 1, ch0 values stable; then READY high → ch0..3 in 4 consecutive cycles, BUSY=0 next cycle.
- START pulsed during CAPTURE and DRAIN → no restart; counts match single-START run.
- RN low at cycle 20 of capture → all outputs 0 immediately; new START after release yields counts from fresh window only.
- With TOGGLE_MON_SYNC_EN, single PROBE[2] rise at cycle k+WINDOW−1 → not counted (falls outside shifted window); at cycle k+WINDOW−3 → ch2 rise=1.

Source files
------------

// File: rtl/toggle_mon_pkg.sv
// Shared types and helpers for toggle_activity_monitor: FSM states, the
// result-beat record and the saturating counter increment.
package toggle_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } state_e;

  // Widest counter and channel index a result beat can carry.
  localparam int SAT_W    = 32;
  localparam int RES_CH_W = 8;

  typedef struct packed {
    logic [RES_CH_W-1:0] ch;
    logic [SAT_W-1:0]    rise;
    logic [SAT_W-1:0]    fall;
    logic                ovf;
  } result_t;

  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                               input logic [SAT_W-1:0] max_v);
    return (v == max_v) ? v : v + SAT_W'(1);
  endfunction

endpackage

// File: rtl/toggle_mon_chan.sv
// One probed channel: previous-value flop, edge detect, saturating rise/fall
// counters and sticky overflow. Exposes next-state values so the top can
// register a beat on the same edge the last window cycle is counted.
module toggle_mon_chan
  import toggle_mon_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          CLK,
  input  logic          RN,
  input  logic          clr,
  input  logic          en,
  input  logic          p,
  output logic [CW-1:0] rise_d,
  output logic [CW-1:0] fall_d,
  output logic          ovf_d
);

  localparam logic [SAT_W-1:0] CNT_MAX = SAT_W'({CW{1'b1}});

  logic          prev_q, prev_d;
  logic [CW-1:0] rise_q, fall_q;
  logic          ovf_q;
  logic          rise_ev, fall_ev;

  assign rise_ev = ~prev_q & p;
  assign fall_ev = prev_q & ~p;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    prev_d = prev_q;
    rise_d = rise_q;
    fall_d = fall_q;
    ovf_d  = ovf_q;
    if (clr) begin
      // Start-of-window edge: load prev only, never compare against it.
      prev_d = p;
      rise_d = '0;
      fall_d = '0;
      ovf_d  = 1'b0;
    end else if (en) begin
      prev_d = p;
      if (rise_ev) begin
        rise_d = CW'(sat_inc(SAT_W'(rise_q), CNT_MAX));
        if (rise_q == {CW{1'b1}}) ovf_d = 1'b1;
      end
      if (fall_ev) begin
        fall_d = CW'(sat_inc(SAT_W'(fall_q), CNT_MAX));
        if (fall_q == {CW{1'b1}}) ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      prev_q <= 1'b0;
      rise_q <= '0;
      fall_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: rtl/toggle_activity_monitor.sv
// Per-channel toggle counter over a fixed window, results streamed over
// valid/ready. Define TOGGLE_MON_SYNC_EN to add a 2-flop PROBE synchronizer.
module toggle_activity_monitor
  import toggle_mon_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int CW     = 16,
  parameter int WINDOW = 64
) (
  input  logic                                   CLK,
  input  logic                                   RN,
  input  logic [NCH-1:0]                         PROBE,
  input  logic                                   START,
  output logic                                   BUSY,
  output logic                                   OUT_VALID,
  input  logic                                   OUT_READY,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] OUT_CH,
  output logic [CW-1:0]                          OUT_RISE,
  output logic [CW-1:0]                          OUT_FALL,
  output logic                                   OUT_OVF
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int WW  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WW-1:0]  WIN_LAST = WW'(WINDOW - 1);
  localparam logic [CHW-1:0] CH_LAST  = CHW'(NCH - 1);

  logic [NCH-1:0] probe_s;

`ifdef TOGGLE_MON_SYNC_EN
  logic [NCH-1:0] sync1_q, sync2_q;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= PROBE;
      sync2_q <= sync1_q;
    end
  end

  assign probe_s = sync2_q;
`else
  assign probe_s = PROBE;
`endif

  state_e         state_q, state_d;
  logic [WW-1:0]  win_q, win_d;
  logic [CHW-1:0] idx_q, idx_d;
  logic           clr, en, load;
  logic           busy_q, valid_q;
  result_t        res_q, res_d;

  logic [CW-1:0] ch_rise [NCH];
  logic [CW-1:0] ch_fall [NCH];
  logic          ch_ovf  [NCH];

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    toggle_mon_chan #(.CW(CW)) u_chan (
      .CLK    (CLK),
      .RN     (RN),
      .clr    (clr),
      .en     (en),
      .p      (probe_s[c]),
      .rise_d (ch_rise[c]),
      .fall_d (ch_fall[c]),
      .ovf_d  (ch_ovf[c])
    );
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    idx_d   = idx_q;
    clr     = 1'b0;
    en      = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          state_d = CAPTURE;
          clr     = 1'b1;
          win_d   = '0;
        end
      end
      CAPTURE: begin
        en    = 1'b1;
        win_d = win_q + WW'(1);
        if (win_q == WIN_LAST) begin
          state_d = DRAIN;
          idx_d   = '0;
          load    = 1'b1;
        end
      end
      DRAIN: begin
        if (OUT_READY) begin
          if (idx_q == CH_LAST) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q + CHW'(1);
            load  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Beats are taken from the channels' next-state values: on the last window
  // edge these include that cycle's edges, and in DRAIN they are frozen.
  always_comb begin
    res_d = res_q;
    if (load) begin
      res_d.ch   = RES_CH_W'(idx_d);
      res_d.rise = SAT_W'(ch_rise[idx_d]);
      res_d.fall = SAT_W'(ch_fall[idx_d]);
      res_d.ovf  = ch_ovf[idx_d];
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      win_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      idx_q   <= idx_d;
      busy_q  <= (state_d != IDLE);
      valid_q <= (state_d == DRAIN);
      res_q   <= res_d;
    end
  end

  assign BUSY      = busy_q;
  assign OUT_VALID = valid_q;
  assign OUT_CH    = res_q.ch[CHW-1:0];
  assign OUT_RISE  = res_q.rise[CW-1:0];
  assign OUT_FALL  = res_q.fall[CW-1:0];
  assign OUT_OVF   = res_q.ovf;

  // Upper record bits beyond CHW/CW stay zero and are intentionally unused.
  logic unused_res_bits;
  assign unused_res_bits = ^res_q;

endmodule
